arb_grant_ctrl: RTL and testbench

- Bus-arbiter controller for up to 3 requesting clients.
- Drives per-client grant lines and the registered bus-owner index (`o_master`), so that whenever `i_ready` is sampled high, `o_master` in the next cycle equals the index granted in that cycle.
- `o_master` = 2'b11 means parked: no grant was asserted.
- Round-robin with a hold limit gives bounded service latency; per-client wait counters flag any starvation.

---
 rtl/arb_pkg.sv | 29 ++
 rtl/arb_grant_ctrl_rr_pick.sv | 34 +++
 rtl/arb_grant_ctrl.sv | 125 ++++++++++++
 tb/tb_arb_grant_ctrl.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and helpers for the arb_grant_ctrl bus arbiter.
// Owner indices are MW bits wide; the all-ones index marks a parked bus.
package arb_pkg;

  localparam int MW          = 2;
  localparam int MAX_CLIENTS = 3;

  localparam logic [MW-1:0] MASTER_PARK = 2'b11;

  typedef enum logic {
    PARK = 1'b0,
    OWN  = 1'b1
  } arb_state_t;

  // Encodes a one-hot (or zero) grant; a zero grant maps to MASTER_PARK.
  function automatic logic [MW-1:0] onehot_to_idx(input logic [MAX_CLIENTS-1:0] oh);
    logic [MW-1:0] idx;
    idx = MASTER_PARK;
    for (int i = 0; i < MAX_CLIENTS; i++) begin
      if (oh[i]) begin
        idx = i[MW-1:0];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_grant_ctrl_rr_pick.sv
// Combinational round-robin picker.
// Scans from rr_ptr upward (mod N) and nominates the first unmasked requester.
module arb_rr_pick
  import arb_pkg::*;
#(
  parameter int N = 3
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] rr_ptr,
  input  logic [N-1:0]  excl,
  output logic [N-1:0]  pick,
  output logic          valid
);

  logic [N-1:0] cand;

  // First candidate found in rotation order wins.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    cand  = req & ~excl;
    for (int k = 0; k < N; k++) begin
      int s;
      s = (int'(rr_ptr) + k) % N;
      if (!valid && cand[s]) begin
        pick[s] = 1'b1;
        valid   = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/arb_grant_ctrl.sv
// Round-robin bus arbiter with per-owner hold limit and starvation flags.
// o_grant nominates the next owner; o_master takes it over on each i_ready edge.
module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter int NUM_CLIENTS  = 3,
  parameter int MAX_HOLD     = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int CW           = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NUM_CLIENTS-1:0] i_req,
  input  logic                   i_ready,
  output logic [NUM_CLIENTS-1:0] o_grant,
  output logic [MW-1:0]          o_master,
  output logic [NUM_CLIENTS-1:0] o_starve
);

  localparam int HW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]          HOLD_SAT = HW'(MAX_HOLD - 1);
  localparam logic [CW-1:0]          WAIT_SAT = {CW{1'b1}};
  localparam logic [CW-1:0]          WAIT_LIM = CW'(STARVE_LIMIT);
  localparam logic [NUM_CLIENTS-1:0] ONE_LSB  = {{(NUM_CLIENTS-1){1'b0}}, 1'b1};

  logic [NUM_CLIENTS-1:0] grant_q, grant_d;
  logic [MW-1:0]          master_q, master_d;
  logic [NUM_CLIENTS-1:0] starve_q, starve_d;
  logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
  logic [MW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]          wait_cnt_q [NUM_CLIENTS];
  logic [CW-1:0]          wait_cnt_d [NUM_CLIENTS];
  arb_state_t             state_q, state_d;

  logic [NUM_CLIENTS-1:0] own_oh, excl, pick;
  logic                   own_req, hold_done, pick_valid;
  logic [MW-1:0]          new_master;

  arb_rr_pick #(.N(NUM_CLIENTS)) u_pick (
    .req    (i_req),
    .rr_ptr (rr_ptr_q),
    .excl   (excl),
    .pick   (pick),
    .valid  (pick_valid)
  );

  // Next nomination: keep the owner until its hold is spent, else rotate.
  always_comb begin
    own_oh    = (state_q == OWN) ? (ONE_LSB << master_q) : '0;
    own_req   = |(own_oh & i_req);
    hold_done = (hold_cnt_q >= HOLD_SAT);
    excl      = hold_done ? own_oh : '0;
    if (own_req && !hold_done) begin
      grant_d = own_oh;
    end else if (pick_valid) begin
      grant_d = pick;
    end else if (own_req) begin
      grant_d = own_oh;
    end else begin
      grant_d = '0;
    end
  end

  // Handover bookkeeping: owner, hold/rotation pointer, wait counters.
  always_comb begin
    new_master = onehot_to_idx(MAX_CLIENTS'(grant_q));
    master_d   = master_q;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      starve_d[i] = (wait_cnt_q[i] >= WAIT_LIM);
    end
    if (i_ready) begin
      master_d = new_master;
      state_d  = (new_master == MASTER_PARK) ? PARK : OWN;
      if (new_master == master_q) begin
        hold_cnt_d = hold_done ? HOLD_SAT : hold_cnt_q + HW'(1);
      end else begin
        hold_cnt_d = '0;
        if (new_master != MASTER_PARK) begin
          rr_ptr_d = (new_master == MW'(NUM_CLIENTS - 1)) ? '0 : new_master + MW'(1);
        end else begin
          rr_ptr_d = rr_ptr_q;
        end
      end
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        if (i_req[i] && !grant_q[i]) begin
          wait_cnt_d[i] = (wait_cnt_q[i] == WAIT_SAT) ? WAIT_SAT : wait_cnt_q[i] + CW'(1);
        end else begin
          wait_cnt_d[i] = '0;
        end
      end
    end else begin
      master_d = master_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      grant_q    <= '0;
      master_q   <= MASTER_PARK;
      starve_q   <= '0;
      hold_cnt_q <= '0;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '{default: '0};
      state_q    <= PARK;
    end else begin
      grant_q    <= grant_d;
      master_q   <= master_d;
      starve_q   <= starve_d;
      hold_cnt_q <= hold_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      state_q    <= state_d;
    end
  end

  assign o_grant  = grant_q;
  assign o_master = master_q;
  assign o_starve = starve_q;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// Directed bench for arb_grant_ctrl: default instance plus a MAX_HOLD=8
// instance whose hold outlasts STARVE_LIMIT, so its starvation flags must fire.
module tb_arb_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       ready;
  logic [2:0] req;
  logic [2:0] grant_a, starve_a, grant_b, starve_b;
  logic [1:0] master_a, master_b;
  logic [2:0] mon_g;
  logic [1:0] mon_want;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  arb_grant_ctrl #(.NUM_CLIENTS(3), .MAX_HOLD(4), .STARVE_LIMIT(8), .CW(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_ready(ready),
    .o_grant(grant_a), .o_master(master_a), .o_starve(starve_a)
  );

  arb_grant_ctrl #(.NUM_CLIENTS(3), .MAX_HOLD(8), .STARVE_LIMIT(8), .CW(4)) dut_hold8 (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_ready(ready),
    .o_grant(grant_b), .o_master(master_b), .o_starve(starve_b)
  );

  // Edges 1..22 after reset with all clients requesting and ready every cycle.
  localparam logic [2:0] A_GRANT [22] = '{
    3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
    3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
    3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
    3'b001, 3'b001, 3'b001, 3'b001, 3'b001,
    3'b010, 3'b010};
  localparam logic [1:0] A_MASTER [22] = '{
    2'd3, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
    2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
    2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
    2'd1};

  // Sparse-ready run continuing from a saturated owner-0 state, ending in release.
  localparam logic       E_READY [18] = '{
    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1,
    1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  localparam logic [2:0] E_REQ [18] = '{
    3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110,
    3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b110, 3'b000, 3'b000};
  localparam logic [2:0] E_GRANT [18] = '{
    3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
    3'b010, 3'b010, 3'b010, 3'b100, 3'b100, 3'b100, 3'b100, 3'b000, 3'b000};
  localparam logic [1:0] E_MASTER [18] = '{
    2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd1,
    2'd1, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3};

  task automatic check(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Handover invariant on the default instance at every ready edge.
  always @(posedge clk) begin
    if (ready && !rst) begin
      mon_g = grant_a;
      case (mon_g)
        3'b001:  mon_want = 2'd0;
        3'b010:  mon_want = 2'd1;
        3'b100:  mon_want = 2'd2;
        default: mon_want = 2'd3;
      endcase
      vectors++;
      assert ($onehot0(mon_g)) else begin
        errors++;
        $error("FAIL grant_onehot: observed %b expected one-hot or zero", mon_g);
      end
      #1;
      vectors++;
      assert (master_a === mon_want) else begin
        errors++;
        $error("FAIL invariant: observed master %0d expected %0d (grant %b)", master_a, mon_want, mon_g);
      end
    end
  end

  initial begin
    rst   = 1'b1;
    ready = 1'b0;
    req   = 3'b000;
    tick();
    check("rst_grant",  grant_a, 3'b000);
    check("rst_master", {1'b0, master_a}, 3'b011);
    check("rst_starve", starve_a, 3'b000);

    rst   = 1'b0;
    req   = 3'b111;
    ready = 1'b1;
    for (int k = 1; k <= 22; k++) begin
      tick();
      check($sformatf("rot_grant_e%0d", k), grant_a, A_GRANT[k-1]);
      check($sformatf("rot_master_e%0d", k), {1'b0, master_a}, {1'b0, A_MASTER[k-1]});
      if (k == 8) check("h8_starve_e8", starve_b, 3'b000);
      if (k == 9) check("h8_starve_e9", starve_b, 3'b110);
      if (k == 9) check("h8_grant_e9", grant_b, 3'b001);
      if (k == 10) check("h8_grant_e10", grant_b, 3'b010);
    end

    rst = 1'b1;
    tick();
    check("midrst_grant",  grant_a, 3'b000);
    check("midrst_master", {1'b0, master_a}, 3'b011);
    check("midrst_starve", starve_a, 3'b000);
    check("midrst_starve_h8", starve_b, 3'b000);

    rst = 1'b0;
    req = 3'b001;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("single_grant_e%0d", k), grant_a, 3'b001);
      check($sformatf("single_master_e%0d", k), {1'b0, master_a}, (k == 1) ? 3'b011 : 3'b000);
    end
    check("single_starve", starve_a, 3'b000);

    for (int k = 0; k < 18; k++) begin
      ready = E_READY[k];
      req   = E_REQ[k];
      tick();
      check($sformatf("sparse_grant_e%0d", k + 1), grant_a, E_GRANT[k]);
      check($sformatf("sparse_master_e%0d", k + 1), {1'b0, master_a}, {1'b0, E_MASTER[k]});
    end
    check("release_starve", starve_a, 3'b000);

    ready = 1'b0;
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
